muller_c_pipeline: RTL and testbench

//   Parametrised, clock-synchronous model of a Sutherland micropipeline.

---
 rtl/muller_c_pkg.sv | 23 ++
 rtl/muller_c_cell.sv | 32 +++
 rtl/muller_c_pipeline.sv | 119 +++++++++++
 tb/tb_muller_c_pipeline.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muller_c_pkg.sv
// Shared types and helpers for the clocked Muller C-element micropipeline.
package muller_c_pkg;

    localparam logic C_RESET_PHASE = 1'b0;

    // Inputs of one pipeline C-element: fwd comes from the predecessor, bwd from the successor.
    typedef struct packed {
        logic bwd;
        logic fwd;
    } stage_ctrl_t;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return width;
    endfunction

    function automatic int occ_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/muller_c_cell.sv
// Generic clocked Muller C-element: the output takes the common value of its
// (optionally inverted) inputs when they all agree, otherwise it holds.
module muller_c_cell
    import muller_c_pkg::*;
#(
    parameter int             NIN      = 2,
    parameter logic [NIN-1:0] INV_MASK = '0,
    parameter logic           RST_VAL  = C_RESET_PHASE
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NIN-1:0] din,
    output logic           q,
    output logic           fire
);

    logic [NIN-1:0] agree;

    assign agree = din ^ INV_MASK;

    // fire is high when q changes on the coming edge; neighbours use it as a load enable.
    assign fire = q ? ~|agree : &agree;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (fire) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/muller_c_pipeline.sv
// Clock-synchronous Sutherland micropipeline: DEPTH C-element stages with bundled data,
// token occupancy, full/empty status and sticky 2-phase protocol-error flags.
module muller_c_pipeline
    import muller_c_pkg::*;
#(
    parameter int   DEPTH     = 4,
    parameter int   WIDTH     = 8,
    parameter logic RST_PHASE = C_RESET_PHASE
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          in_req,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ack,
    output logic                          out_req,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ack,
    output logic [occ_width(DEPTH)-1:0]   occupancy,
    output logic                          empty,
    output logic                          full,
    output logic                          in_err,
    output logic                          out_err
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] c;
    logic [DEPTH-1:0] fire;
    logic [DEPTH-1:0] fwd;
    logic [DEPTH-1:0] bwd;
    logic [DEPTH-1:0] held;

    logic [WIDTH-1:0] d   [DEPTH];
    logic [WIDTH-1:0] src [DEPTH];

    logic in_req_q;
    logic out_ack_q;

    // fwd[i] is c[i-1] (in_req for stage 0); bwd[i] is c[i+1] (out_ack for the last stage).
    assign fwd  = {c[DEPTH-2:0], in_req};
    assign bwd  = {out_ack, c[DEPTH-1:1]};
    assign held = c ^ bwd;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        stage_ctrl_t ctrl;

        assign ctrl.fwd = fwd[i];
        assign ctrl.bwd = bwd[i];

        muller_c_cell #(
            .NIN      (2),
            .INV_MASK (2'b10),
            .RST_VAL  (RST_PHASE)
        ) u_cell (
            .clk  (wb_clk_i),
            .rst  (wb_rst_i),
            .din  (ctrl),
            .q    (c[i]),
            .fire (fire[i])
        );
    end

    always_comb begin
        src[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src[i] = d[i-1];
        end
    end

    // Bundled data: a stage captures its predecessor's pre-edge value whenever its C-element toggles.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fire[i]) begin
                    d[i] <= src[i];
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(held[i]);
        end
    end

    assign empty = (occupancy == '0);
    assign full  = (occupancy == OCC_W'(DEPTH));

    // A request may only change once the previous one was acknowledged, and an
    // acknowledge may only change while a token is offered; the registered copies give the pre-edge view.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            in_req_q  <= RST_PHASE;
            out_ack_q <= RST_PHASE;
            in_err    <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            in_req_q  <= in_req;
            out_ack_q <= out_ack;
            if ((in_req != in_req_q) && (in_req_q != c[0])) begin
                in_err <= 1'b1;
            end
            if ((out_ack != out_ack_q) && (out_ack_q == c[DEPTH-1])) begin
                out_err <= 1'b1;
            end
        end
    end

    assign in_ack   = c[0];
    assign out_req  = c[DEPTH-1];
    assign out_data = d[DEPTH-1];

endmodule

// File: tb/tb_muller_c_pipeline.sv
// Self-checking bench for muller_c_pipeline against a token/slot model of the
// 2-phase micropipeline, with directed scenarios and randomized traffic.
module tb_muller_c_pipeline;

    localparam int   DEPTH     = 4;
    localparam int   WIDTH     = 8;
    localparam logic RST_PHASE = 1'b0;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_req;
    logic [WIDTH-1:0] in_data;
    logic             in_ack;
    logic             out_req;
    logic [WIDTH-1:0] out_data;
    logic             out_ack;
    logic [2:0]       occupancy;
    logic             empty;
    logic             full;
    logic             in_err;
    logic             out_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muller_c_pipeline #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .RST_PHASE (RST_PHASE)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .in_req    (in_req),
        .in_data   (in_data),
        .in_ack    (in_ack),
        .out_req   (out_req),
        .out_data  (out_data),
        .out_ack   (out_ack),
        .occupancy (occupancy),
        .empty     (empty),
        .full      (full),
        .in_err    (in_err),
        .out_err   (out_err)
    );

    // Reference model: slots 0..DEPTH-2 hold tokens; the last slot is occupied while
    // out_req differs from out_ack. A token moves into a slot that was free before the edge.
    logic [DEPTH-2:0] m_occ;
    logic [7:0]       m_dat [DEPTH];
    logic             m_in_ack, m_out_req, m_in_err, m_out_err, m_req_prev, m_ack_prev;
    logic [DEPTH-1:0] has_tok, is_free, mv;
    int               m_count;
    logic [16:0]      exp_vec, dut_vec;

    assign has_tok = {m_occ, in_req != m_in_ack};
    assign is_free = {m_out_req == out_ack, ~m_occ};
    assign mv      = has_tok & is_free;
    assign m_count = $countones(m_occ) + int'(m_out_req ^ out_ack);
    assign exp_vec = {m_in_ack, m_out_req, m_dat[DEPTH-1], 3'(m_count),
                      m_count == 0, m_count == DEPTH, m_in_err, m_out_err};
    assign dut_vec = {in_ack, out_req, out_data, occupancy, empty, full, in_err, out_err};

    always @(posedge clk) begin
        if (rst) begin
            m_occ <= '0;
            for (int i = 0; i < DEPTH; i++) m_dat[i] <= '0;
            m_in_ack   <= RST_PHASE;
            m_out_req  <= RST_PHASE;
            m_in_err   <= 1'b0;
            m_out_err  <= 1'b0;
            m_req_prev <= RST_PHASE;
            m_ack_prev <= RST_PHASE;
        end else begin
            for (int i = 0; i < DEPTH - 1; i++) m_occ[i] <= mv[i] | (m_occ[i] & ~mv[i+1]);
            if (mv[0]) m_dat[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) if (mv[i]) m_dat[i] <= m_dat[i-1];
            if (mv[0]) m_in_ack <= ~m_in_ack;
            if (mv[DEPTH-1]) m_out_req <= ~m_out_req;
            m_req_prev <= in_req;
            m_ack_prev <= out_ack;
            if (in_req != m_req_prev && m_req_prev != m_in_ack) m_in_err <= 1'b1;
            if (out_ack != m_ack_prev && m_ack_prev == m_out_req) m_out_err <= 1'b1;
        end
    end

    task automatic test_reset();
        rst = 1'b1; in_req = RST_PHASE; out_ack = RST_PHASE; in_data = '0;
        repeat (2) @(negedge clk);
        tests++;
        if (dut_vec !== 17'b0_0_00000000_000_1_0_0_0) begin
            fails++;
            $display("FAIL reset_state: got %h want %h", dut_vec, 17'b0_0_00000000_000_1_0_0_0);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        in_data = 8'hA5; in_req = ~in_req;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            tests++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL single_model n=%0d: dut %h model %h", n, dut_vec, exp_vec); end
            tests++;
            if (in_ack !== 1'b1 || occupancy !== 3'd1) begin
                fails++; $display("FAIL single_ack_occ n=%0d: in_ack %b occ %0d want 1 1", n, in_ack, occupancy);
            end
            tests++;
            if (out_req !== (n == 4)) begin fails++; $display("FAIL single_latency n=%0d: out_req %b want %b", n, out_req, n == 4); end
        end
        tests++;
        if (out_data !== 8'hA5) begin fails++; $display("FAIL single_data: got %h want a5", out_data); end
        out_ack = ~out_ack;
        @(negedge clk);
        tests++;
        if (occupancy !== 3'd0 || empty !== 1'b1) begin fails++; $display("FAIL single_consume: occ %0d empty %b want 0 1", occupancy, empty); end
    endtask

    task automatic test_fill();
        logic [7:0] want [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [7:0] got [$];
        logic       ack_hold;
        int         cyc;
        for (int k = 0; k < 4; k++) begin
            in_data = want[k]; in_req = ~in_req;
            for (cyc = 0; cyc < 10 && in_req != m_in_ack; cyc++) begin
                @(negedge clk);
                tests++;
                if (dut_vec !== exp_vec) begin fails++; $display("FAIL fill_model: dut %h model %h", dut_vec, exp_vec); end
            end
        end
        repeat (6) @(negedge clk);
        tests++;
        if (full !== 1'b1 || occupancy !== 3'd4) begin fails++; $display("FAIL fill_full: full %b occ %0d want 1 4", full, occupancy); end
        ack_hold = in_ack;
        in_data = want[4]; in_req = ~in_req;
        repeat (10) begin
            @(negedge clk);
            tests++;
            if (in_ack !== ack_hold || dut_vec !== exp_vec) begin
                fails++; $display("FAIL fill_blocked: in_ack %b want %b dut %h model %h", in_ack, ack_hold, dut_vec, exp_vec);
            end
        end
        for (cyc = 0; cyc < 80 && got.size() < 5; cyc++) begin
            if (m_out_req != out_ack) begin got.push_back(out_data); out_ack = ~out_ack; end
            @(negedge clk);
            tests++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL drain_model: dut %h model %h", dut_vec, exp_vec); end
        end
        tests++;
        if (got.size() != 5) begin fails++; $display("FAIL drain_count: got %0d want 5", got.size()); end
        for (int k = 0; k < got.size() && k < 5; k++) begin
            tests++;
            if (got[k] !== want[k]) begin fails++; $display("FAIL drain_order[%0d]: got %h want %h", k, got[k], want[k]); end
        end
    endtask

    task automatic test_traffic(input string name, input int n_tok, input int p_prod, input int p_cons);
        logic [7:0] sb [$];
        logic [7:0] exp_d;
        int         sent, got, cyc;
        sent = 0; got = 0;
        for (cyc = 0; cyc < 3000 && got < n_tok; cyc++) begin
            @(negedge clk);
            tests++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL %s_model: dut %h model %h", name, dut_vec, exp_vec); end
            if (m_out_req != out_ack && $urandom_range(99) < p_cons) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL %s_extra: got %h want no token", name, out_data);
                end else begin
                    exp_d = sb.pop_front();
                    if (out_data !== exp_d) begin fails++; $display("FAIL %s_data: got %h want %h", name, out_data, exp_d); end
                end
                got++;
                out_ack = ~out_ack;
            end
            if (in_req == m_in_ack && sent < n_tok && $urandom_range(99) < p_prod) begin
                in_data = 8'($urandom);
                sb.push_back(in_data);
                in_req = ~in_req;
                sent++;
            end
        end
        tests++;
        if (got != n_tok) begin fails++; $display("FAIL %s_timeout: got %0d tokens want %0d", name, got, n_tok); end
        @(negedge clk);
        tests++;
        if ({in_err, out_err} !== 2'b00) begin fails++; $display("FAIL %s_errs: got %b want 00", name, {in_err, out_err}); end
    endtask

    task automatic test_violation();
        int push;
        push = 0;
        rst = 1'b1; in_req = RST_PHASE; out_ack = RST_PHASE;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ack = ~out_ack;
        @(negedge clk);
        tests++;
        if (out_err !== 1'b1 || in_err !== 1'b0) begin fails++; $display("FAIL out_err_set: in %b out %b want 0 1", in_err, out_err); end
        for (int cyc = 0; cyc < 40 && m_count != DEPTH; cyc++) begin
            if (in_req == m_in_ack) begin in_data = 8'h81 + 8'(push); in_req = ~in_req; push++; end
            @(negedge clk);
            tests++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL viol_fill_model: dut %h model %h", dut_vec, exp_vec); end
        end
        tests++;
        if (full !== 1'b1) begin fails++; $display("FAIL viol_full: got %b want 1", full); end
        in_data = 8'h84; in_req = ~in_req;
        @(negedge clk);
        in_req = ~in_req;
        @(negedge clk);
        tests++;
        if (in_err !== 1'b1) begin fails++; $display("FAIL in_err_set: got %b want 1", in_err); end
        repeat (5) begin
            @(negedge clk);
            tests++;
            if ({in_err, out_err} !== 2'b11 || dut_vec !== exp_vec) begin
                fails++; $display("FAIL err_sticky: errs %b want 11 dut %h model %h", {in_err, out_err}, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ack = ~out_ack;
        repeat (4) begin
            @(negedge clk);
            tests++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL mid_prep_model: dut %h model %h", dut_vec, exp_vec); end
        end
        tests++;
        if (occupancy !== 3'd3 || out_data !== 8'h81 || {in_err, out_err} !== 2'b11) begin
            fails++; $display("FAIL mid_prep: occ %0d data %h errs %b want 3 81 11", occupancy, out_data, {in_err, out_err});
        end
        rst = 1'b1; in_req = RST_PHASE; out_ack = RST_PHASE;
        @(negedge clk);
        tests++;
        if (dut_vec !== 17'b0_0_00000000_000_1_0_0_0) begin
            fails++; $display("FAIL mid_reset: got %h want %h", dut_vec, 17'b0_0_00000000_000_1_0_0_0);
        end
        rst = 1'b0;
        in_data = 8'h3C; in_req = ~in_req;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            tests++;
            if (out_req !== (n == 4) || dut_vec !== exp_vec) begin
                fails++; $display("FAIL mid_token n=%0d: out_req %b dut %h model %h", n, out_req, dut_vec, exp_vec);
            end
        end
        tests++;
        if (out_data !== 8'h3C) begin fails++; $display("FAIL mid_token_data: got %h want 3c", out_data); end
        out_ack = ~out_ack;
        @(negedge clk);
        tests++;
        if (empty !== 1'b1 || {in_err, out_err} !== 2'b00) begin
            fails++; $display("FAIL mid_after: empty %b errs %b want 1 00", empty, {in_err, out_err});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_traffic("stream", 20, 100, 100);
        test_traffic("random", 60, 50, 40);
        test_violation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
